// File: rtl/pid_pkg.sv
// Shared PID controller types and default sizing.
// Holds the sequencing FSM encoding used by the PID term blocks.
package pid_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int EW_DEF    = 8;
  localparam int KW_DEF    = 6;
  localparam int DEPTH_DEF = 4;
  localparam int OW_DEF    = 12;

endpackage

// File: rtl/shift_add_mul.sv
// Sequential signed x unsigned shift-add multiplier, one b bit per cycle.
// Ports: clk, rst (async high), start_i, a_i (signed AW), b_i (unsigned BW),
//        done_o (high in the cycle of the final step), p_o (signed AW+BW).
module shift_add_mul #(
  parameter int AW = 9,
  parameter int BW = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic signed [AW-1:0] a_i,
  input  logic [BW-1:0]        b_i,
  output logic                 done_o,
  output logic signed [AW+BW-1:0] p_o
);

  localparam int PW = AW + BW;
  localparam int CW = $clog2(BW + 1);

  logic signed [PW-1:0] mc_q, mc_d;
  logic signed [PW-1:0] acc_q, acc_d;
  logic [BW-1:0]        mp_q, mp_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 run_q, run_d;
  logic                 last;

  // last step lands in acc_q at the coming edge;
  // p_o is final from the following cycle on
  assign last   = run_q && (cnt_q == CW'(BW - 1));
  assign done_o = last;
  assign p_o    = acc_q;

  always_comb begin
    mc_d  = mc_q;
    acc_d = acc_q;
    mp_d  = mp_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start_i) begin
      mc_d  = PW'(a_i);
      mp_d  = b_i;
      acc_d = '0;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      if (mp_q[0]) begin
        acc_d = acc_q + mc_q;
      end
      mc_d  = mc_q <<< 1;
      mp_d  = mp_q >> 1;
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mc_q  <= '0;
      acc_q <= '0;
      mp_q  <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      mc_q  <= mc_d;
      acc_q <= acc_d;
      mp_q  <= mp_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/pid_derivative.sv
// PID derivative term: sample history, difference, gain multiply, saturate.
// Ports: clk, rst (async high), ena, e, k_d, mode in; busy, d_contrib,
//        d_valid out. mode 0 = single-step, 1 = DEPTH-span averaged diff.
module pid_derivative
  import pid_pkg::*;
#(
  parameter int EW    = EW_DEF,
  parameter int KW    = KW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int OW    = OW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic signed [EW-1:0] e,
  input  logic [KW-1:0]        k_d,
  input  logic                 mode,
  output logic                 busy,
  output logic signed [OW-1:0] d_contrib,
  output logic                 d_valid
);

  localparam int DW = EW + 1;
  localparam int PW = DW + KW;
  localparam int LD = $clog2(DEPTH);
  localparam int SW = (PW > OW) ? PW : OW;

  state_t state_q, state_d;

  logic signed [EW-1:0] hist_q [DEPTH];
  logic signed [EW-1:0] hist_d [DEPTH];
  logic                 primed_q, primed_d;
  logic signed [OW-1:0] dc_q, dc_d;
  logic                 dv_q, dv_d;

  logic                 accept;
  logic signed [EW-1:0] newest, oldest;
  logic signed [DW-1:0] step, span, diff;
  logic                 mul_done;
  logic signed [PW-1:0] prod;

  function automatic logic signed [OW-1:0] sat(
    input logic signed [PW-1:0] x
  );
    logic signed [SW-1:0] xs, hi, lo;
    xs         = SW'(x);
    hi         = '0;
    hi[OW-2:0] = '1;
    lo         = ~hi;
    if (xs > hi) begin
      sat = hi[OW-1:0];
    end else if (xs < lo) begin
      sat = lo[OW-1:0];
    end else begin
      sat = xs[OW-1:0];
    end
  endfunction

  assign accept = ena && (state_q == S_IDLE);
  assign busy   = (state_q != S_IDLE);

  // before priming, history reads as the incoming sample -> diff 0
  assign newest = primed_q ? hist_q[0] : e;
  assign oldest = primed_q ? hist_q[DEPTH-1] : e;
  assign step   = DW'(e) - DW'(newest);
  assign span   = DW'(e) - DW'(oldest);
  assign diff   = mode ? (span >>> LD) : step;

  shift_add_mul #(
    .AW (DW),
    .BW (KW)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start_i (accept),
    .a_i     (diff),
    .b_i     (k_d),
    .done_o  (mul_done),
    .p_o     (prod)
  );

  always_comb begin
    hist_d   = hist_q;
    primed_d = primed_q;
    if (accept) begin
      primed_d = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        if (!primed_q || i == 0) begin
          hist_d[i] = e;
        end else begin
          hist_d[i] = hist_q[i-1];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dc_d    = dc_q;
    dv_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        if (mul_done) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        dc_d    = sat(prod);
        dv_d    = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      dc_q     <= '0;
      dv_q     <= 1'b0;
      primed_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      dc_q     <= dc_d;
      dv_q     <= dv_d;
      primed_q <= primed_d;
      hist_q   <= hist_d;
    end
  end

  assign d_contrib = dc_q;
  assign d_valid   = dv_q;

endmodule

// File: tb/tb_pid_derivative.sv
// Self-checking bench for pid_derivative (EW=8, KW=6, DEPTH=4, OW=12).
// Directed cases plus random samples against a sample-history model.
module tb_pid_derivative;

  localparam int EW = 8;
  localparam int KW = 6;
  localparam int DEPTH = 4;
  localparam int OW = 12;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 ena = 1'b0;
  logic signed [EW-1:0] e = '0;
  logic [KW-1:0]        k_d = '0;
  logic                 mode = 1'b0;
  logic                 busy;
  logic signed [OW-1:0] d_contrib;
  logic                 d_valid;

  int checks = 0;
  int errors = 0;

  int  h [DEPTH];
  bit  primed = 0;
  int  last_exp = 0;

  pid_derivative #(
    .EW(EW), .KW(KW), .DEPTH(DEPTH), .OW(OW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .e         (e),
    .k_d       (k_d),
    .mode      (mode),
    .busy      (busy),
    .d_contrib (d_contrib),
    .d_valid   (d_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int floor_div(input int n, input int d);
    if (n >= 0) return n / d;
    return -((-n + d - 1) / d);
  endfunction

  // reference: result of accepting sample ev with gain kv and mode mv
  task automatic model(input int ev, input int kv, input bit mv,
                       output int res);
    int diff, p, hi, lo;
    if (!primed) begin
      for (int i = 0; i < DEPTH; i++) h[i] = ev;
      primed = 1;
    end
    if (mv) diff = floor_div(ev - h[DEPTH-1], DEPTH);
    else    diff = ev - h[0];
    for (int i = DEPTH - 1; i > 0; i--) h[i] = h[i-1];
    h[0] = ev;
    p  = diff * kv;
    hi = (1 << (OW - 1)) - 1;
    lo = -(1 << (OW - 1));
    res = (p > hi) ? hi : (p < lo) ? lo : p;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ena = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    primed = 0;
  endtask

  task automatic run(input string tag, input int ev, input int kv,
                     input bit mv);
    int exp, n;
    bit seen;
    @(negedge clk);
    e = EW'(ev);
    k_d = KW'(kv);
    mode = mv;
    ena = 1'b1;
    @(posedge clk);
    #1 ena = 1'b0;
    model(ev, kv, mv, exp);
    n = 0;
    seen = 0;
    while (!seen && n < 20) begin
      @(posedge clk);
      n++;
      #1 if (d_valid) seen = 1;
    end
    check({tag, "_lat"}, n, KW + 1);
    check({tag, "_val"}, int'(d_contrib), exp);
    check({tag, "_idle"}, int'(busy), 0);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, int'(d_valid), 0);
    check({tag, "_hold"}, int'(d_contrib), exp);
    last_exp = exp;
  endtask

  initial begin
    int exp, dv_cnt, ev, kv;
    bit mv;

    // reset state
    rst = 1'b1;
    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(d_valid), 0);
    check("rst_out", int'(d_contrib), 0);
    @(negedge clk);
    rst = 1'b0;

    // first sample after reset differences to zero
    run("first", 20, 5, 0);

    do_reset();
    run("s10", 10, 3, 0);
    run("s30", 30, 3, 0);
    check("step60", last_exp, 60);

    // saturation both ways
    do_reset();
    run("p127", 127, 63, 0);
    run("n128", -128, 63, 0);
    check("satneg", int'(d_contrib), -2048);
    run("p127b", 127, 63, 0);
    check("satpos", int'(d_contrib), 2047);

    // averaged span
    do_reset();
    for (int i = 0; i < 5; i++) run("ramp", 8 * i, 2, 1);
    check("ramp16", int'(d_contrib), 16);

    // ena during busy is ignored; busy spans T+1..T+7
    @(negedge clk);
    e = EW'(40);
    k_d = KW'(3);
    mode = 1'b0;
    ena = 1'b1;
    @(posedge clk);
    #1 ena = 1'b0;
    model(40, 3, 0, exp);
    dv_cnt = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n <= 8) check("busy_win", int'(busy), (n <= 7) ? 1 : 0);
      if (n == 2) begin
        e = EW'(-90);
        ena = 1'b1;
      end
      @(posedge clk);
      #1 ena = 1'b0;
      if (d_valid) dv_cnt++;
    end
    check("one_valid", dv_cnt, 1);
    check("ign_val", int'(d_contrib), exp);
    run("after_ign", 44, 3, 0);

    // async reset mid-multiply
    do_reset();
    run("r100", 100, 5, 0);
    run("r110", 110, 5, 0);
    check("pre_rst", int'(d_contrib), 50);
    @(negedge clk);
    e = EW'(60);
    k_d = KW'(7);
    ena = 1'b1;
    @(posedge clk);
    #1 ena = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_busy", int'(busy), 0);
    check("mid_valid", int'(d_valid), 0);
    check("mid_out", int'(d_contrib), 0);
    dv_cnt = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (n == 2) rst = 1'b0;
      if (d_valid) dv_cnt++;
    end
    check("no_valid", dv_cnt, 0);
    primed = 0;
    run("r50", 50, 9, 0);
    check("r50_zero", int'(d_contrib), 0);

    // random samples
    do_reset();
    for (int i = 0; i < 40; i++) begin
      ev = int'($urandom_range(255)) - 128;
      kv = (i % 9 == 4) ? 0 : int'($urandom_range(63));
      mv = 1'($urandom_range(1));
      run("rnd", ev, kv, mv);
      repeat ($urandom_range(2)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
